// File: rtl/csa_mult_seq_pkg.sv
// Shared types and helpers for the sequential carry-save multiplier front end.
// Holds the FSM state encoding and the iteration-counter width rule.
package csa_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csa_state_t;

  // Counter must index N iterations (0 .. N-1); never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/csa_mult_seq_row.sv
// Combinational 3:2 compressor row: per-bit full adders reduce x+y+z to s+c.
// The carry vector is returned unshifted; the caller applies the weight shift.
module csa_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

module csa_row #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    csa_fa u_fa (
      .x(x[i]),
      .y(y[i]),
      .z(z[i]),
      .s(s[i]),
      .c(c[i])
    );
  end
endmodule

// File: rtl/csa_mult_seq.sv
// Sequential radix-2 carry-save multiplier: one partial product per cycle,
// emitting a redundant sum/carry row pair for a downstream 2N-bit adder.
module csa_mult_seq
  import csa_mult_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] sum_row,
  output logic [2*N-1:0] carry_row,
  output logic           busy
);

  localparam int W  = 2 * N;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  csa_state_t      state;
  logic [W-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic [W-1:0]    s_reg;
  logic [W-1:0]    c_reg;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    pp;
  logic [W-1:0]    row_s;
  logic [W-1:0]    row_c;

  assign pp = b_reg[0] ? a_reg : '0;

  csa_row #(.W(W)) u_row (
    .x(s_reg),
    .y(c_reg),
    .z(pp),
    .s(row_s),
    .c(row_c)
  );

  // Handshake flags decode the state register only, never an input.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum_row   = s_reg;
  assign carry_row = c_reg;

  // NOTE: every register here uses <= so all updates in a cycle see the
  // pre-edge values; with = the carry would be computed from the new sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, because an aborted
      // operation must leave zero rows on the outputs, not stale data.
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      c_reg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= {{N{1'b0}}, a};
            b_reg <= b;
            s_reg <= '0;
            c_reg <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Carry moves up one weight; the bit leaving the top is always zero.
          s_reg <= row_s;
          c_reg <= {row_c[W-2:0], 1'b0};
          a_reg <= {a_reg[W-2:0], 1'b0};
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
